// File: rtl/led_matrix_scan.sv
// HUB75 panel scanner: double-buffered framebuffer, bit-angle modulation with
// per-plane weighted on-time, buffer swap only on a frame boundary.
//
// state     | meaning
// S_SHIFT   | clock one row of plane bits into the panel, two cycles per column
// S_LATCH   | latch shifted data, drive the new row address
// S_DISPLAY | unblank for BASE_ON << plane cycles
module led_matrix_scan #(
  parameter int COLS     = 32,
  parameter int COL_BITS = 5,
  parameter int ROW_BITS = 4,
  parameter int DEPTH    = 4,
  parameter int BASE_ON  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ROW_BITS+COL_BITS:0]   wr_addr,
  input  logic [3*DEPTH-1:0]           wr_data,
  input  logic                         swap_req,
  output logic                         swap_ack,
  output logic                         frame_start,
  output logic                         clk_screen,
  output logic                         R0,
  output logic                         G0,
  output logic                         B0,
  output logic                         R1,
  output logic                         G1,
  output logic                         B1,
  output logic                         blank,
  output logic                         latch,
  output logic [ROW_BITS-1:0]          row
);

  localparam int AW = ROW_BITS + COL_BITS + 2;
  localparam int CW = COL_BITS + 1;
  localparam int PB = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2((BASE_ON << (DEPTH - 1)) + 1);
  localparam logic [CW-1:0]       SHIFT_LAST = CW'(2 * COLS - 1);
  localparam logic [CW-1:0]       COLS_LIM   = CW'(COLS);
  localparam logic [PB-1:0]       PLANE_LAST = PB'(DEPTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST   = '1;

  typedef enum logic [1:0] {S_SHIFT, S_LATCH, S_DISPLAY} state_t;

  state_t state, state_nxt;
  logic [CW-1:0]       shift_cnt;
  logic [PB-1:0]       plane_cnt;
  logic [ROW_BITS-1:0] row_cnt;
  logic [ROW_BITS-1:0] row_q;
  logic [TW-1:0]       on_timer;
  logic                front;
  logic [3*DEPTH-1:0]  fb [2**AW];
  logic [COL_BITS-1:0] col;
  logic [3*DEPTH-1:0]  pix_top, pix_bot;
  logic shift_done, on_done, frame_end, do_swap;

  assign col        = shift_cnt[COL_BITS:1];
  assign shift_done = (state == S_SHIFT) && (shift_cnt == SHIFT_LAST);
  assign on_done    = (state == S_DISPLAY) && (on_timer == '0);
  assign frame_end  = on_done && (plane_cnt == PLANE_LAST) && (row_cnt == ROW_LAST);
  assign do_swap    = rst && frame_end && swap_req;

  // Buffer select is the MSB; top and bottom panel halves differ only in the y MSB.
  assign pix_top = fb[{front, 1'b0, row_cnt, col}];
  assign pix_bot = fb[{front, 1'b1, row_cnt, col}];

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr[COL_BITS-1:0]} < COLS_LIM))
      fb[{~front, wr_addr}] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_SHIFT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_SHIFT:   if (shift_done) state_nxt = S_LATCH;
      S_LATCH:   state_nxt = S_DISPLAY;
      S_DISPLAY: if (on_timer == '0) state_nxt = S_SHIFT;
      default:   state_nxt = S_SHIFT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_cnt <= '0;
      plane_cnt <= '0;
      row_cnt   <= '0;
      row_q     <= '0;
      on_timer  <= '0;
      front     <= 1'b0;
    end else begin
      if (state == S_SHIFT)
        shift_cnt <= shift_done ? '0 : shift_cnt + CW'(1);
      if (state == S_LATCH) begin
        on_timer <= TW'((BASE_ON << plane_cnt) - 1);
        row_q    <= row_cnt;
      end else if ((state == S_DISPLAY) && (on_timer != '0)) begin
        on_timer <= on_timer - TW'(1);
      end
      if (on_done) begin
        plane_cnt <= (plane_cnt == PLANE_LAST) ? '0 : plane_cnt + PB'(1);
        // SCAN is a power of two, so the row counter wraps on its own
        if (plane_cnt == PLANE_LAST) row_cnt <= row_cnt + ROW_BITS'(1);
      end
      if (do_swap) front <= ~front;
    end
  end

  // Reset gating keeps colour and pulse outputs quiet while rst is held low.
  always_comb begin
    clk_screen  = 1'b0;
    {R0, G0, B0, R1, G1, B1} = 6'b0;
    blank       = 1'b1;
    latch       = 1'b0;
    frame_start = 1'b0;
    swap_ack    = 1'b0;
    row         = row_q;
    case (state)
      S_SHIFT: begin
        clk_screen  = shift_cnt[0];
        frame_start = rst && (shift_cnt == '0) && (plane_cnt == '0) && (row_cnt == '0);
        if (rst) begin
          R0 = pix_top[2*DEPTH + int'(plane_cnt)];
          G0 = pix_top[DEPTH + int'(plane_cnt)];
          B0 = pix_top[int'(plane_cnt)];
          R1 = pix_bot[2*DEPTH + int'(plane_cnt)];
          G1 = pix_bot[DEPTH + int'(plane_cnt)];
          B1 = pix_bot[int'(plane_cnt)];
        end
      end
      S_LATCH: begin
        latch = 1'b1;
        row   = row_cnt;
      end
      S_DISPLAY: begin
        blank    = 1'b0;
        swap_ack = do_swap;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/led_matrix_scan.md
LED_MATRIX_SCAN -- requirements
Module: led_matrix_scan

Interface
REQ-001 SHALL have parameter COLS, default 32: panel columns shifted per row.
REQ-002 SHALL have parameter COL_BITS, default 5: x address width, COLS <= 2**COL_BITS.
REQ-003 SHALL have parameter ROW_BITS, default 4: scan-line count SCAN = 2**ROW_BITS, panel height 2*SCAN.
REQ-004 SHALL have parameter DEPTH, default 4: bitplanes per colour channel.
REQ-005 SHALL have parameter BASE_ON, default 32: display cycles of bitplane 0.
REQ-006 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port wr_en  in  1  write strobe into the back buffer.
REQ-009 SHALL have port wr_addr  in  ROW_BITS+1+COL_BITS  write address {y, x}.
REQ-010 SHALL have port wr_data  in  3*DEPTH  pixel {R[DEPTH-1:0], G, B}.
REQ-011 SHALL have port swap_req  in  1  level request to exchange front/back buffers.
REQ-012 SHALL have port swap_ack  out  1  one-cycle pulse when the swap is performed.
REQ-013 SHALL have port frame_start  out  1  one-cycle pulse at first SHIFT cycle of row 0, plane 0.
REQ-014 SHALL have ports clk_screen, R0, G0, B0, R1, G1, B1, blank, latch  out  1 each  HUB75 signals.
REQ-015 SHALL have port row  out  ROW_BITS  HUB75 row address.

Function
REQ-016 SHALL hold two framebuffers of COLS*2*SCAN words of 3*DEPTH bits; front is scanned, back is written.
REQ-017 SHALL write wr_data to back[y][x] on clk when wr_en=1; x >= COLS SHALL be ignored.
REQ-018 SHALL sequence states SHIFT -> LATCH -> DISPLAY -> SHIFT per (row, plane), plane inner loop, row outer loop.
REQ-019 SHIFT SHALL last exactly 2*COLS cycles: for column c, cycle 2c clk_screen=0 with data for c valid, cycle 2c+1 clk_screen=1, data held.
REQ-020 In SHIFT, R0/G0/B0 SHALL be bit p of front[r][c] channels and R1/G1/B1 bit p of front[r+SCAN][c], p = current plane, r = current row.
REQ-021 LATCH SHALL last 1 cycle: latch=1, clk_screen=0, row updated to r.
REQ-022 DISPLAY SHALL last BASE_ON << p cycles with blank=0; blank SHALL be 1 in SHIFT and LATCH.
REQ-023 After DISPLAY of p = DEPTH-1, plane SHALL wrap to 0 and row increment; after row SCAN-1 row SHALL wrap to 0 (frame end).
REQ-024 Frame length SHALL be SCAN*sum over p of (2*COLS + 1 + (BASE_ON << p)) cycles.
REQ-025 At frame end with swap_req=1, swap_ack SHALL pulse in the last DISPLAY cycle and front/back SHALL exchange from the next cycle.
REQ-026 swap_req deasserted before frame end SHALL cancel the request; no swap_ack.
REQ-027 A write in the swap_ack cycle SHALL land in the pre-swap back buffer.
REQ-028 Colour outputs SHALL be 0 outside SHIFT.

Reset
REQ-029 rst=0 SHALL immediately force clk_screen=0, colours=0, blank=1, latch=0, row=0, swap_ack=0, frame_start=0, front=buffer 0, state=SHIFT, row/plane/column counters=0.
REQ-030 Buffer contents SHALL NOT be reset; reset mid-frame SHALL abort the frame and restart at row 0 plane 0 after release, frame_start in first cycle after release.

Verification (COLS=4, COL_BITS=2, ROW_BITS=1, DEPTH=2, BASE_ON=2)
REQ-031 Reset release, no writes -> frame_start every 48 cycles, blank low 2 then 4 cycles per row, colours always 0.
REQ-032 Write back[0][1]=6'b11_00_00, swap -> next frame row 0 plane 0 and plane 1: R0=1 only on column 1 shift cycles; R1=0.
REQ-033 Write back[3][0]=6'b00_00_01 -> after swap B1=1 at row=1, plane 0 only, column 0.
REQ-034 swap_req pulsed mid-frame and dropped -> no swap_ack; swap_req held -> swap_ack once at cycle 47 of frame.
REQ-035 rst low for 1 cycle during DISPLAY of row 1 -> blank=1, row=0 immediately; buffer data preserved on next frame.
REQ-036 wr_addr with x=3 valid, COLS=3 build: x=3 write ignored, scan shifts 6 cycles/row-plane.
